// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared definitions for the integer execution cluster.
// Holds the ALU opcode set, the M-extension funct3 encodings, the
// multiply/divide FSM state encoding and small opcode decode helpers.
package muldiv_unit_pkg;

  // Base integer ALU operations
  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_SLL  = 4'h2,
    ALU_SLT  = 4'h3,
    ALU_SLTU = 4'h4,
    ALU_XOR  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_OR   = 4'h8,
    ALU_AND  = 4'h9
  } alu_op_e;

  // M-extension operations, encoded as their funct3 field
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  // Multiply/divide sequencer states
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Divide family is the upper half of the funct3 space
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // REM/REMU return the remainder rather than the quotient
  function automatic logic op_is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // rs1 is interpreted as two's complement
  function automatic logic op_rs1_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is interpreted as two's complement
  function automatic logic op_rs2_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// muldiv_div_iter: restoring radix-2 divider datapath on unsigned magnitudes.
// One quotient bit per step; the next-state quotient/remainder are exported
// so the parent can capture the final, sign-corrected value on the last step.
module muldiv_div_iter
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo_next,
  output logic [WIDTH-1:0] rem_next
);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // Trial subtract of the divisor from the partial remainder with the next dividend bit shifted in
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (!diff[WIDTH]) begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Quotient register doubles as the dividend shift register
  always_ff @(posedge clk) begin
    if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (step) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RISC-V M-extension multiply/divide unit.
// Multiplies use shift-add on magnitudes, divides use muldiv_div_iter; both
// take WIDTH iterations. Divide-by-zero and signed overflow finish at once.
// Build macro MULDIV_FAST_MUL_EN: multiplies use one registered wide
// multiplier and finish one cycle after accept; divides are unaffected.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             result_valid
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0]  MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Two's complement negate when the sign flag is set
  function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_wide_if(input logic neg, input logic [2*WIDTH-1:0] v);
    return neg ? -v : v;
  endfunction

  md_state_e          state;
  md_state_e          state_nxt;
  logic [CNT_W-1:0]   count;
  logic [2:0]         op_q;
  logic               neg_prod_q;
  logic               neg_rem_q;

  logic               sgn1;
  logic               sgn2;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic               div_zero;
  logic               div_ovf;
  logic               bypass;
  logic [WIDTH-1:0]   bypass_val;
  logic               accept;
  logic               last;

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH:0]     psum;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_nxt;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   final_val;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*WIDTH+1:0] fast_a;
  logic signed [2*WIDTH+1:0] fast_b;
  logic signed [2*WIDTH+1:0] fast_p;
`endif

  // Operand decode: sign flags, magnitudes and the early-completion cases
  always_comb begin
    sgn1     = op_rs1_signed(opcode) & data1[WIDTH-1];
    sgn2     = op_rs2_signed(opcode) & data2[WIDTH-1];
    mag1     = neg_if(sgn1, data1);
    mag2     = neg_if(sgn2, data2);
    div_zero = op_is_div(opcode) && (data2 == '0);
    div_ovf  = op_is_div(opcode) && !opcode[0] && (data1 == MOST_NEG) && (data2 == '1);
    bypass   = div_zero | div_ovf;
    // Overflow yields quotient = dividend and remainder = 0
    if (op_is_rem(opcode)) begin
      bypass_val = div_zero ? data1 : '0;
    end else begin
      bypass_val = div_zero ? '1 : data1;
    end
`ifdef MULDIV_FAST_MUL_EN
    fast_a = {{(WIDTH+2){sgn1}}, data1};
    fast_b = {{(WIDTH+2){op_rs2_signed(opcode) & data2[WIDTH-1]}}, data2};
    fast_p = fast_a * fast_b;
    if (!op_is_div(opcode)) begin
      bypass     = 1'b1;
      bypass_val = (opcode == MD_MUL) ? fast_p[WIDTH-1:0] : fast_p[2*WIDTH-1:WIDTH];
    end
`endif
  end

  // Handshake qualifiers: flush always beats start; a busy unit does not queue
  always_comb begin
    accept = start && !flush && (state != MD_CALC);
    last   = (state == MD_CALC) && (count == CNT_ONE);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MD_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = MD_IDLE;
    end else begin
      case (state)
        MD_IDLE, MD_DONE: begin
          if (start) begin
            state_nxt = bypass ? MD_DONE : MD_CALC;
          end else begin
            state_nxt = MD_IDLE;
          end
        end
        MD_CALC: begin
          if (count == CNT_ONE) begin
            state_nxt = MD_DONE;
          end
        end
        default: state_nxt = MD_IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    busy         = (state == MD_CALC);
    result_valid = (state == MD_DONE);
  end

  // Iteration counter and latched opcode / sign-correction flags
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      op_q       <= 3'b000;
      neg_prod_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else if (flush) begin
      count <= '0;
    end else if (accept) begin
      count      <= bypass ? '0 : CNT_LOAD;
      op_q       <= opcode;
      neg_prod_q <= sgn1 ^ sgn2;
      neg_rem_q  <= sgn1;
    end else if (state == MD_CALC) begin
      count <= count - CNT_ONE;
    end
  end

  // Shift-add step: add multiplicand when the current multiplier bit is set, then shift right
  always_comb begin
    psum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_nxt = {psum, prod_q[WIDTH-1:1]};
  end

  // Multiplier datapath: upper half accumulates, lower half holds remaining multiplier bits
  always_ff @(posedge clk) begin
    if (accept) begin
      mcand_q <= mag1;
      prod_q  <= {{WIDTH{1'b0}}, mag2};
    end else if (busy) begin
      prod_q <= prod_nxt;
    end
  end

  muldiv_div_iter #(
    .WIDTH (WIDTH)
  ) u_div_iter (
    .clk      (clk),
    .load     (accept),
    .step     (busy),
    .dividend (mag1),
    .divisor  (mag2),
    .quo_next (quo_nxt),
    .rem_next (rem_nxt)
  );

  // Final-iteration sign correction and result selection
  always_comb begin
    prod_fix = neg_wide_if(neg_prod_q, prod_nxt);
    quo_fix  = neg_if(neg_prod_q, quo_nxt);
    rem_fix  = neg_if(neg_rem_q, rem_nxt);
    if (!op_is_div(op_q)) begin
      final_val = (op_q == MD_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    end else if (op_is_rem(op_q)) begin
      final_val = rem_fix;
    end else begin
      final_val = quo_fix;
    end
  end

  // Result register only changes on the edge that enters DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
    end else if (accept && bypass) begin
      result <= bypass_val;
    end else if (last && !flush) begin
      result <= final_val;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed self-checking bench for muldiv_unit
// (WIDTH=32) against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        flush;
  logic [2:0]  opcode;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [31:0] result;
  logic        busy;
  logic        result_valid;

  int          checks;
  int          errors;
  int          cyc_now;
  int          acc_cyc;
  logic [31:0] prev_res;

  muldiv_unit #(
    .WIDTH (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .flush        (flush),
    .opcode       (opcode),
    .data1        (data1),
    .data2        (data2),
    .result       (result),
    .busy         (busy),
    .result_valid (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_now++;
  endtask

  // Reference result computed from the M-extension arithmetic rules
  function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    case (op)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      default: begin
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
        case (op)
          3'b100:  return ia / ib;
          3'b101:  return a / b;
          3'b110:  return ia % ib;
          default: return a % b;
        endcase
      end
    endcase
  endfunction

  // Cycles from the accept edge until the result-valid cycle
  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2]) return (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    opcode = op;
    data1  = a;
    data2  = b;
    tick();
    acc_cyc = cyc_now;
    start   = 1'b0;
    opcode  = 3'($urandom_range(0, 7));
    data1   = $urandom;
    data2   = $urandom;
  endtask

  // Called in cycle 1 after accept; returns in the result-valid cycle
  task automatic wait_result(input logic [31:0] exp, input int exp_lat);
    if (exp_lat > 1) chk("hold_in_calc", result, prev_res);
    chk("busy_c1", 32'(busy), 32'(exp_lat > 1));
    while (!result_valid && (cyc_now - acc_cyc) < 80) tick();
    chk("latency", 32'(cyc_now - acc_cyc + 1), 32'(exp_lat));
    chk("result", result, exp);
    prev_res = exp;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] e;
    int          l;
    e = model_res(op, a, b);
    l = model_lat(op, a, b);
    issue(op, a, b);
    wait_result(e, l);
  endtask

  task automatic do_dir(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    int l;
    l = model_lat(op, a, b);
    issue(op, a, b);
    wait_result(e, l);
  endtask

  task automatic quiet(input int n, input string tag);
    int pulses;
    pulses = 0;
    repeat (n) begin
      tick();
      if (result_valid) pulses++;
    end
    chk(tag, 32'(pulses), 32'd0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    checks   = 0;
    errors   = 0;
    cyc_now  = 0;
    acc_cyc  = 0;
    prev_res = 32'd0;
    reset    = 1'b1;
    start    = 1'b0;
    flush    = 1'b0;
    opcode   = 3'b000;
    data1    = 32'd0;
    data2    = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_result", result, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);

    // Directed corner cases, issued back-to-back in the DONE cycle
    do_dir(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    do_dir(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    do_dir(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_dir(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_dir(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    do_dir(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    do_dir(3'b101, 32'd100, 32'd7, 32'd14);
    do_dir(3'b111, 32'd100, 32'd7, 32'd2);
    do_dir(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF);
    do_dir(3'b110, 32'd5, 32'd0, 32'd5);
    do_dir(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF);
    do_dir(3'b111, 32'd5, 32'd0, 32'd5);
    do_dir(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    do_dir(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    tick();
    chk("valid_drop", 32'(result_valid), 32'd0);

    // Flush at CALC cycle 10, new divide on the next cycle
    issue(3'b100, 32'd1000, 32'd7);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_valid", 32'(result_valid), 32'd0);
    chk("flush_hold", result, prev_res);
    do_op(3'b100, 32'hFFFF_FF9C, 32'd7);

    // Flush and start on the same edge: start is dropped
    tick();
    start  = 1'b1;
    flush  = 1'b1;
    opcode = 3'b101;
    data1  = 32'd9;
    data2  = 32'd0;
    tick();
    start = 1'b0;
    flush = 1'b0;
    chk("fs_busy", 32'(busy), 32'd0);
    chk("fs_valid", 32'(result_valid), 32'd0);
    chk("fs_hold", result, prev_res);

    // Start during CALC is ignored and not queued
    issue(3'b101, 32'd12345, 32'd11);
    repeat (4) tick();
    start  = 1'b1;
    opcode = 3'b000;
    data1  = 32'd3;
    data2  = 32'd3;
    tick();
    start = 1'b0;
    wait_result(model_res(3'b101, 32'd12345, 32'd11), 33);
    quiet(40, "no_queue");
    chk("idle_hold", result, prev_res);

    // Reset mid-CALC overrides concurrent start and flush
    issue(3'b000, 32'd123, 32'd456);
    repeat (9) tick();
    reset  = 1'b1;
    start  = 1'b1;
    flush  = 1'b1;
    opcode = 3'b101;
    tick();
    reset = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    prev_res = 32'd0;
    chk("midrst_result", result, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(result_valid), 32'd0);
    quiet(40, "midrst_quiet");

    // Randomized operations, mixing idle-cycle and back-to-back accepts
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        tick();
        chk("rand_valid_drop", 32'(result_valid), 32'd0);
      end
      do_op(3'($urandom_range(0, 7)), rand_operand(), rand_operand());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal values 8..64, even.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 START  input  1  request strobe; operands/opcode sampled when accepted.
REQ-005 FLUSH  input  1  pipeline flush; cancels any in-flight operation.
REQ-006 OPCODE  input  3  M-extension funct3: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
REQ-007 DATA1  input  WIDTH  rs1 operand (dividend / multiplicand).
REQ-008 DATA2  input  WIDTH  rs2 operand (divisor / multiplier).
REQ-009 RESULT  output  WIDTH  registered result.
REQ-010 BUSY  output  1  high while an operation iterates.
REQ-011 RESULT_VALID  output  1  one-cycle pulse marking RESULT valid.

Function
REQ-012 FSM states IDLE, CALC, DONE; BUSY = (state==CALC); RESULT_VALID = (state==DONE).
REQ-013 START accepted only in IDLE or DONE; START in CALC is ignored, no queuing.
REQ-014 Accepted START -> CALC, iteration counter loaded with WIDTH; operands, opcode, sign flags latched.
REQ-015 CALC decrements counter each cycle; at counter==1 next state DONE; RESULT_VALID therefore asserted exactly WIDTH+1 cycles after accept edge.
REQ-016 DONE lasts one cycle -> IDLE, or -> CALC/DONE on back-to-back accepted START.
REQ-017 RESULT holds its value from DONE until the next DONE; never changes otherwise.
REQ-018 MUL returns product bits [WIDTH-1:0]; MULH/MULHSU/MULHU return bits [2*WIDTH-1:WIDTH] of signed x signed, signed x unsigned, unsigned x unsigned 2*WIDTH-bit product respectively.
REQ-019 Multiply: shift-add on magnitudes, one multiplier bit per cycle, sign correction in final cycle.
REQ-020 Divide: restoring radix-2, one quotient bit per cycle; signed ops divide magnitudes, quotient negated if signs differ, remainder takes dividend sign.
REQ-021 DIVU/DIV by zero: quotient all ones; REM/REMU by zero: remainder = DATA1.
REQ-022 DIV signed overflow (DATA1 = most-negative, DATA2 = all ones): quotient = DATA1; REM returns 0.
REQ-023 Div-by-zero and overflow cases bypass CALC: accept -> DONE, RESULT_VALID one cycle after accept.
REQ-024 FLUSH high at an edge -> IDLE next cycle, no RESULT_VALID for cancelled op, RESULT unchanged.
REQ-025 FLUSH and START same edge: FLUSH wins, START dropped.

Reset
REQ-026 RESET high at edge: state IDLE, counter 0, RESULT 0, BUSY 0, RESULT_VALID 0.
REQ-027 RESET overrides FLUSH and START, including mid-CALC; aborted operation never signals.

Configuration
REQ-028 Macro MULDIV_FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU computed by single registered 2*WIDTH-bit multiplier, accept -> DONE, RESULT_VALID one cycle after accept; divides unchanged.
REQ-029 Macro undefined: all multiplies iterate per REQ-015/REQ-019; no wide multiplier instantiated.

Structure
REQ-030 Opcode encodings and FSM state encodings reside in the shared definitions file alongside existing ALU opcode defines.
REQ-031 Divider datapath (remainder/quotient shift registers, trial subtract) as sub-module muldiv_div_iter; FSM, counter, multiplier and sign fix-up in muldiv_unit.

Verification
REQ-032 WIDTH=32, MUL 7 x -3 -> RESULT 0xFFFFFFEB, RESULT_VALID at cycle 33 after accept (cycle 1 with MULDIV_FAST_MUL_EN).
REQ-033 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-034 DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
REQ-035 DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; all valid 1 cycle after accept.
REQ-036 START DIV, FLUSH at CALC cycle 10, new START next cycle -> no pulse for first op, second op result correct after 33 cycles.
REQ-037 RESET asserted mid-CALC; START in CALC ignored; back-to-back START in DONE accepted -> outputs zero after reset, no spurious RESULT_VALID.
